channel_multi_cc_filtered: RTL and testbench

// - Parametrised successor of the per-CC thread channel between coprocessor engines.
// - Buffers {pc, cc_id} entries in a FWFT ring buffer and tracks per-CC occupancy (present_cc_id).
// - Estimates wait latency for upstream arbitration.
// - New: a kill_mask discards entries of cancelled CCs at input and at head, with a saturating

---
 rtl/channel_pkg.sv | 36 +++
 rtl/channel_multi_cc_filtered_ring_buffer.sv | 68 ++++++
 rtl/channel_multi_cc_filtered.sv | 139 +++++++++++++
 tb/tb_channel_multi_cc_filtered.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// rtl/channel_pkg.sv - shared types and saturating arithmetic for the per-CC thread channel
//
// Purpose: entry types for the channel ({pc, cc_id}) at the default widths, and a
// saturating add used by the latency estimator and the drop counter.
// Ports: none (package).

package channel_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT   = 8;
  localparam int unsigned CC_ID_BITS_DEFAULT = 2;

  typedef logic [CC_ID_BITS_DEFAULT-1:0] cc_id_t;
  typedef logic [PC_WIDTH_DEFAULT-1:0]   pc_t;

  typedef struct packed {
    pc_t    pc;
    cc_id_t cc_id;
  } channel_entry_t;

  // value + amount, clamped to the all-ones value of a width-bit field.
  // The sum is formed one bit wider than the operands so it cannot wrap.
  // Callers pass zero-extended operands and cast the result back to width bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] amount,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, value} + {1'b0, amount};
    max_val = (33'd1 << width) - 33'd1;
    if (sum > max_val) begin
      return max_val[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/channel_multi_cc_filtered_ring_buffer.sv
// rtl/channel_multi_cc_filtered_ring_buffer.sv - FWFT ring buffer storage for the channel
//
// Purpose: circular storage with read/write pointers and an occupancy count.
// The head entry is presented combinationally (first-word fall-through).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   write         store wr_data at the write pointer (never asserted when full)
//   pop           retire the head entry (never asserted when empty)
//   wr_data       entry to store
//   rd_data       current head entry, mem[rd_ptr]
//   count         registered occupancy
//   full, empty   derived from count

module channel_ring_buffer #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write,
  input  logic                   pop,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // Storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly DEPTH_LOG2 bits wide, so wrap-around is implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == COUNT_WIDTH'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/channel_multi_cc_filtered.sv
// rtl/channel_multi_cc_filtered.sv - per-CC thread channel with kill filtering and latency estimate
//
// Purpose: buffers {pc, cc_id} entries, tracks which contexts have stored entries,
// estimates wait latency for upstream arbitration and discards entries of cancelled
// contexts both at the input and at the head.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     upstream entry handshake, data = {pc, cc_id}
//   in_latency     estimated wait cycles for a newly pushed entry
//   out_valid/out_ready/out_data  downstream head handshake
//   out_latency    downstream latency estimate
//   kill_mask      level, bit i cancels cc_id i
//   present_cc_id  bit i set while any stored entry has cc_id i
//   almost_full    count >= DEPTH - AF_MARGIN
//   drop_count     saturating count of entries discarded by kill_mask

module channel_multi_cc_filtered
  import channel_pkg::*;
#(
  parameter int unsigned PC_WIDTH            = 8,
  parameter int unsigned CC_ID_BITS          = 2,
  parameter int unsigned DEPTH_LOG2          = 4,
  parameter int unsigned CHANNEL_COUNT_WIDTH = 5,
  parameter int unsigned LATENCY_COUNT_WIDTH = 10,
  parameter int unsigned AF_MARGIN           = 2,
  parameter int unsigned DROP_COUNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PC_WIDTH+CC_ID_BITS-1:0] in_data,
  output logic [LATENCY_COUNT_WIDTH-1:0] in_latency,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PC_WIDTH+CC_ID_BITS-1:0] out_data,
  input  logic [LATENCY_COUNT_WIDTH-1:0] out_latency,
  input  logic [2**CC_ID_BITS-1:0]       kill_mask,
  output logic [2**CC_ID_BITS-1:0]       present_cc_id,
  output logic                           almost_full,
  output logic [DROP_COUNT_WIDTH-1:0]    drop_count
);

  localparam int unsigned DATA_WIDTH = PC_WIDTH + CC_ID_BITS;
  localparam int unsigned NUM_CC     = 2 ** CC_ID_BITS;
  localparam int unsigned DEPTH      = 2 ** DEPTH_LOG2;
  localparam int unsigned AF_LEVEL   = DEPTH - AF_MARGIN;

  logic [CHANNEL_COUNT_WIDTH-1:0] count;
  logic                           full;
  logic                           empty;
  logic [DATA_WIDTH-1:0]          head_data;
  logic [CC_ID_BITS-1:0]          in_cc;
  logic [CC_ID_BITS-1:0]          head_cc;
  logic                           push;
  logic                           in_kill;
  logic                           write;
  logic                           head_kill;
  logic                           pop;
  logic [1:0]                     drop_amt;
  logic [LATENCY_COUNT_WIDTH-1:0] old_latency;

  assign in_cc   = in_data[CC_ID_BITS-1:0];
  assign head_cc = head_data[CC_ID_BITS-1:0];

  // in_ready depends only on registered count: no pass-through when full.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  // A killed input is still accepted (handshake completes) but never stored.
  assign in_kill = push && kill_mask[in_cc];
  assign write   = push && !kill_mask[in_cc];

  // A killed head is retired without waiting for out_ready, one per cycle.
  assign head_kill = !empty && kill_mask[head_cc];
  assign out_valid = !empty && !head_kill;
  assign pop       = (out_valid && out_ready) || head_kill;
  assign out_data  = head_data;

  channel_ring_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .COUNT_WIDTH (CHANNEL_COUNT_WIDTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Per-CC occupancy counters; bounded by DEPTH so they cannot overflow.
  for (genvar i = 0; i < NUM_CC; i++) begin : g_cc
    logic                           inc;
    logic                           dec;
    logic [CHANNEL_COUNT_WIDTH-1:0] cnt;

    assign inc = write && (in_cc == CC_ID_BITS'(i));
    assign dec = pop && (head_cc == CC_ID_BITS'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else begin
        case ({inc, dec})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign present_cc_id[i] = (cnt != '0);
  end

  // Input discard and head drop can coincide, so the drop counter may step by 2.
  assign drop_amt = {1'b0, in_kill} + {1'b0, head_kill};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count  <= '0;
      old_latency <= LATENCY_COUNT_WIDTH'(1);
    end else begin
      drop_count  <= DROP_COUNT_WIDTH'(sat_inc(32'(drop_count), 32'(drop_amt),
                                               DROP_COUNT_WIDTH));
      old_latency <= LATENCY_COUNT_WIDTH'(sat_inc(32'(out_latency), 32'd1,
                                                  LATENCY_COUNT_WIDTH));
    end
  end

  assign in_latency  = LATENCY_COUNT_WIDTH'(sat_inc(32'(old_latency), 32'(count),
                                                    LATENCY_COUNT_WIDTH));
  assign almost_full = (count >= CHANNEL_COUNT_WIDTH'(AF_LEVEL));

endmodule

// File: tb/tb_channel_multi_cc_filtered.sv
// tb/tb_channel_multi_cc_filtered.sv - directed self-checking bench for channel_multi_cc_filtered

module tb_channel_multi_cc_filtered;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic [9:0] in_latency;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [9:0] out_latency;
  logic [3:0] kill_mask;
  logic [3:0] present_cc_id;
  logic       almost_full;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  channel_multi_cc_filtered dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_latency    (in_latency),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_latency   (out_latency),
    .kill_mask     (kill_mask),
    .present_cc_id (present_cc_id),
    .almost_full   (almost_full),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    out_latency = '0; kill_mask = '0;
    step(); step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (present_cc_id !== 4'b0000) begin errors++; $display("FAIL reset_present got=%b exp=0000", present_cc_id); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    checks++; if (in_latency !== 10'd1) begin errors++; $display("FAIL reset_in_latency got=%0d exp=1", in_latency); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    rst = 1'b0;
    step();
    checks++; if (in_latency !== 10'd1) begin errors++; $display("FAIL release_in_latency got=%0d exp=1", in_latency); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(i), 2'd1};
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready_%0d got=%b exp=1", i, in_ready); end
      step();
      if (i == 12) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_at_13 got=%b exp=0", almost_full); end
      end
      if (i == 13) begin
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_at_14 got=%b exp=1", almost_full); end
      end
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    checks++; if (present_cc_id !== 4'b0010) begin errors++; $display("FAIL full_present got=%b exp=0010", present_cc_id); end
    checks++; if (out_valid !== 1'b1 || out_data !== 10'h001) begin errors++; $display("FAIL full_head got=%b/%h exp=1/001", out_valid, out_data); end
    checks++; if (in_latency !== 10'd17) begin errors++; $display("FAIL full_in_latency got=%0d exp=17", in_latency); end
  endtask

  task automatic test_full_pop();
    int popped;
    logic bad_order;
    in_valid  = 1'b1;
    in_data   = {8'hAA, 2'd1};
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready got=%b exp=1", in_ready); end
    checks++; if (in_latency !== 10'd16) begin errors++; $display("FAIL full_pop_count15 got=%0d exp=16", in_latency); end
    checks++; if (out_data !== {8'd1, 2'd1}) begin errors++; $display("FAIL full_pop_head got=%h exp=%h", out_data, {8'd1, 2'd1}); end
    popped = 0; bad_order = 1'b0;
    for (int c = 0; c < 40 && out_valid === 1'b1; c++) begin
      if (out_data !== {8'(popped + 1), 2'd1}) bad_order = 1'b1;
      popped++;
      step();
    end
    out_ready = 1'b0;
    checks++; if (popped != 15 || bad_order) begin errors++; $display("FAIL drain popped=%0d order_bad=%b exp=15/0", popped, bad_order); end
    checks++; if (present_cc_id !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL drained present=%b out_valid=%b exp=0000/0", present_cc_id, out_valid); end
  endtask

  task automatic test_kill_head();
    logic [7:0] pcs [3] = '{8'd10, 8'd30, 8'd20};
    logic [1:0] ccs [3] = '{2'd0, 2'd0, 2'd2};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = {pcs[i], ccs[i]};
      step();
    end
    in_valid = 1'b0;
    checks++; if (present_cc_id !== 4'b0101) begin errors++; $display("FAIL kill_pre_present got=%b exp=0101", present_cc_id); end
    kill_mask = 4'b0001;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL kill_same_cycle out_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0 || drop_count !== 16'd1) begin errors++; $display("FAIL kill_cycle1 out_valid=%b drop=%0d exp=0/1", out_valid, drop_count); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== {8'd20, 2'd2}) begin errors++; $display("FAIL kill_cc2_head got=%b/%h exp=1/%h", out_valid, out_data, {8'd20, 2'd2}); end
    checks++; if (drop_count !== 16'd2 || present_cc_id !== 4'b0100) begin errors++; $display("FAIL kill_totals drop=%0d present=%b exp=2/0100", drop_count, present_cc_id); end
    kill_mask = 4'b0000;
  endtask

  task automatic test_double_drop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {8'd40, 2'd3}; step();
    in_data = {8'd50, 2'd1}; step();
    kill_mask = 4'b1000;
    in_data = {8'd60, 2'd3};
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dd_pre out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    kill_mask = 4'b0000;
    checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL dd_drop got=%0d exp=4", drop_count); end
    checks++; if (in_latency !== 10'd2) begin errors++; $display("FAIL dd_count1 in_latency got=%0d exp=2", in_latency); end
    checks++; if (out_valid !== 1'b1 || out_data !== {8'd50, 2'd1} || present_cc_id !== 4'b0010) begin errors++; $display("FAIL dd_head got=%b/%h/%b exp=1/%h/0010", out_valid, out_data, present_cc_id, {8'd50, 2'd1}); end
  endtask

  task automatic test_latency();
    out_latency = 10'd1023;
    step();
    checks++; if (in_latency !== 10'd1023) begin errors++; $display("FAIL lat_sat got=%0d exp=1023", in_latency); end
    out_latency = 10'd5;
    in_valid = 1'b1; in_data = {8'd70, 2'd1}; step();
    in_data = {8'd71, 2'd1}; step();
    in_valid = 1'b0;
    checks++; if (in_latency !== 10'd9) begin errors++; $display("FAIL lat_5_cnt3 got=%0d exp=9", in_latency); end
    out_latency = 10'd0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {8'(80 + i), 2'd2}; step();
    end
    in_valid = 1'b0;
    checks++; if (in_latency !== 10'd8) begin errors++; $display("FAIL mid_count7 in_latency got=%0d exp=8", in_latency); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || present_cc_id !== 4'b0000) begin errors++; $display("FAIL mid_rst_async out_valid=%b in_ready=%b present=%b exp=0/1/0000", out_valid, in_ready, present_cc_id); end
    checks++; if (in_latency !== 10'd1 || drop_count !== 16'd0 || almost_full !== 1'b0) begin errors++; $display("FAIL mid_rst_vals lat=%0d drop=%0d af=%b exp=1/0/0", in_latency, drop_count, almost_full); end
    step();
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || in_latency !== 10'd1) begin errors++; $display("FAIL mid_release out_valid=%b lat=%0d exp=0/1", out_valid, in_latency); end
  endtask

  task automatic test_back_to_back();
    logic bad;
    bad = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = {8'(100 + k), 2'(k % 4)};
      if (k > 0) begin
        if (out_valid !== 1'b1 || out_data !== {8'(100 + k - 1), 2'((k - 1) % 4)}) bad = 1'b1;
        if (in_latency !== 10'd2) bad = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (bad) begin errors++; $display("FAIL b2b_stream stream data/latency deviated from single-entry pipeline"); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || present_cc_id !== 4'b0000) begin errors++; $display("FAIL b2b_empty out_valid=%b present=%b exp=0/0000", out_valid, present_cc_id); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_kill_head();
    test_double_drop();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
